// File: rtl/word_frame_tx.sv
// UART frame transmitter: takes a 32-bit capture word plus channel index and sends it as a
// 7-byte frame (sync, channel, data MSB byte first, checksum) in 8N1 format, LSB first.
module word_frame_tx #(
  parameter int         BAUD_PRESCALER = 434,
  parameter int         CH_BITS        = 2,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [31:0]        i_data,
  input  logic [CH_BITS-1:0] i_ch,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_busy,
  output logic               tx
);

  localparam int               CNT_W     = $clog2(BAUD_PRESCALER);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_PRESCALER - 1);
  localparam logic [2:0]       LAST_BYTE = 3'd6;
  localparam logic [2:0]       LAST_BIT  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   baud_cnt;
  logic [2:0]         bit_idx;
  logic [2:0]         byte_idx;
  logic [7:0]         shift_reg;
  logic [31:0]        data_q;
  logic [CH_BITS-1:0] ch_q;
  logic               busy_q;
  logic               tx_q;

  logic               accept;
  logic               bit_end;
  logic [7:0]         ch_byte;
  logic [7:0]         checksum;
  logic [7:0]         next_byte;

  assign o_ready = (state == S_IDLE) && !i_rst;
  assign accept  = i_valid && o_ready;
  assign bit_end = (baud_cnt == CNT_LAST);
  assign o_busy  = busy_q;
  assign tx      = tx_q;

  assign ch_byte  = 8'(ch_q);
  assign checksum = SYNC_BYTE + ch_byte + data_q[31:24] + data_q[23:16]
                  + data_q[15:8] + data_q[7:0];

  // Byte that follows the one currently indexed by byte_idx.
  always_comb begin
    next_byte = checksum;
    case (byte_idx)
      3'd0:    next_byte = ch_byte;
      3'd1:    next_byte = data_q[31:24];
      3'd2:    next_byte = data_q[23:16];
      3'd3:    next_byte = data_q[15:8];
      3'd4:    next_byte = data_q[7:0];
      default: next_byte = checksum;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      ch_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            data_q    <= i_data;
            ch_q      <= i_ch;
            shift_reg <= SYNC_BYTE;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            state     <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= shift_reg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              tx_q  <= 1'b1;
              state <= S_STOP;
            end else begin
              shift_reg <= shift_reg >> 1;
              tx_q      <= shift_reg[1];
              bit_idx   <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // The stop bit flows straight into the next start bit so bytes have no gaps.
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (byte_idx == LAST_BYTE) begin
              busy_q <= 1'b0;
              state  <= S_IDLE;
            end else begin
              byte_idx  <= byte_idx + 1'b1;
              shift_reg <= next_byte;
              tx_q      <= 1'b0;
              state     <= S_START;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_frame_tx.sv
// Self-checking bench for word_frame_tx: every bit time of every frame is compared against a
// frame model built from the byte layout, plus reset, back-to-back and abort scenarios.
module tb_word_frame_tx;

  localparam int P = 4;
  localparam int FRAME_CLKS = 70 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data = '0;
  logic [1:0]  ch = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic        busy;
  logic        tx;

  int checks = 0;
  int errors = 0;

  word_frame_tx #(
    .BAUD_PRESCALER(P),
    .CH_BITS(2),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_data(data),
    .i_ch(ch),
    .i_valid(valid),
    .o_ready(ready),
    .o_busy(busy),
    .tx(tx)
  );

  always #5 clk = ~clk;

  // Frame model: byte j sits at bits [8*j +: 8].
  function automatic logic [55:0] model_frame(input logic [31:0] d, input logic [1:0] c);
    int          sum;
    logic [55:0] f;
    sum = 'hA5 + int'(c) + int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]);
    f = {8'(sum % 256), d[7:0], d[15:8], d[23:16], d[31:24], 6'd0, c, 8'hA5};
    return f;
  endfunction

  function automatic logic model_bit(input logic [55:0] f, input int k);
    int pos;
    pos = k % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return f[8 * (k / 10) + pos - 1];
  endfunction

  task automatic start_word(input logic [31:0] d, input logic [1:0] c);
    int tries;
    tries = 0;
    @(negedge clk);
    while (ready !== 1'b1 && tries < 2000) begin
      @(negedge clk);
      tries++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_timeout got %b exp 1", ready);
    end
    data  = d;
    ch    = c;
    valid = 1'b1;
    @(posedge clk);
  endtask

  // Called just after an accept edge; checks every clock of the frame and the idle cycle after.
  task automatic expect_frame(input logic [31:0] d, input logic [1:0] c, input int abort_at,
                              input logic nv, input logic [31:0] nd, input logic [1:0] nc,
                              output logic [55:0] rx);
    logic [55:0] f;
    logic        eb;
    int          k;
    f  = model_frame(d, c);
    rx = '0;
    for (int n = 0; n < FRAME_CLKS; n++) begin
      @(negedge clk);
      k  = n / P;
      eb = model_bit(f, k);
      checks++;
      if (tx !== eb) begin
        errors++;
        $display("[TB] FAIL frame_bit n=%0d bit=%0d got %b exp %b", n, k, tx, eb);
      end
      if (n % P == 0) begin
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL frame_flags n=%0d got busy=%b ready=%b exp busy=1 ready=0",
                   n, busy, ready);
        end
      end
      if (n % P == P / 2 && (k % 10) >= 1 && (k % 10) <= 8)
        rx[8 * (k / 10) + (k % 10) - 1] = tx;
      if (n == 0) begin
        valid = nv;
        data  = nd;
        ch    = nc;
      end
      if (n == abort_at) begin
        rst = 1'b1;
        return;
      end
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL frame_end got tx=%b ready=%b busy=%b exp tx=1 ready=1 busy=0",
               tx, ready, busy);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    valid = 1'b1;
    data  = $urandom;
    ch    = 2'($urandom_range(0, 3));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1 || ready !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold got tx=%b ready=%b busy=%b exp tx=1 ready=0 busy=0",
                 tx, ready, busy);
      end
    end
    rst   = 1'b0;
    valid = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready got %b exp 1", ready);
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle got tx=%b busy=%b exp tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_single();
    logic [55:0] rx;
    start_word(32'h12345678, 2'd2);
    expect_frame(32'h12345678, 2'd2, -1, 1'b0, 32'h0, 2'd0, rx);
    checks++;
    if (rx !== 56'hBB_78_56_34_12_02_A5) begin
      errors++;
      $display("[TB] FAIL single_bytes got %h exp bb78563412 02a5", rx);
    end
  endtask

  task automatic test_input_hold();
    logic [55:0] rx;
    logic [31:0] d;
    d = $urandom;
    start_word(d, 2'd1);
    expect_frame(d, 2'd1, -1, 1'b0, ~d, 2'd2, rx);
    checks++;
    if (rx !== model_frame(d, 2'd1)) begin
      errors++;
      $display("[TB] FAIL input_hold got %h exp %h", rx, model_frame(d, 2'd1));
    end
  endtask

  task automatic test_back_to_back();
    logic [55:0] rx1, rx2;
    logic [31:0] d1, d2;
    logic [1:0]  c1, c2;
    d1 = $urandom;
    d2 = $urandom;
    c1 = 2'($urandom_range(0, 3));
    c2 = 2'($urandom_range(0, 3));
    start_word(d1, c1);
    expect_frame(d1, c1, -1, 1'b1, d2, c2, rx1);
    @(posedge clk);
    expect_frame(d2, c2, -1, 1'b0, 32'h0, 2'd0, rx2);
    checks++;
    if (rx1 !== model_frame(d1, c1) || rx2 !== model_frame(d2, c2)) begin
      errors++;
      $display("[TB] FAIL back_to_back got %h %h exp %h %h", rx1, rx2,
               model_frame(d1, c1), model_frame(d2, c2));
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [55:0] rx;
    logic [31:0] d;
    int          bad;
    d = $urandom;
    start_word(d, 2'd3);
    expect_frame(d, 2'd3, 32 * P + 1, 1'b0, 32'h0, 2'd0, rx);
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort got tx=%b busy=%b ready=%b exp tx=1 busy=0 ready=0",
               tx, busy, ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_release_ready got %b exp 1", ready);
    end
    bad = 0;
    for (int i = 0; i < 12 * P; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_resume got %0d active cycles exp 0", bad);
    end
    d = $urandom;
    start_word(d, 2'd0);
    expect_frame(d, 2'd0, -1, 1'b0, 32'h0, 2'd0, rx);
    checks++;
    if (rx !== model_frame(d, 2'd0)) begin
      errors++;
      $display("[TB] FAIL after_abort got %h exp %h", rx, model_frame(d, 2'd0));
    end
  endtask

  task automatic test_checksum_wrap();
    logic [55:0] rx;
    start_word(32'hFFFFFFFF, 2'd3);
    expect_frame(32'hFFFFFFFF, 2'd3, -1, 1'b0, 32'h0, 2'd0, rx);
    checks++;
    if (rx[55:48] !== 8'hA4 || rx !== 56'hA4_FF_FF_FF_FF_03_A5) begin
      errors++;
      $display("[TB] FAIL checksum_wrap got %h exp a4ffffffff03a5", rx);
    end
  endtask

  task automatic test_random();
    logic [55:0] rx;
    logic [31:0] d;
    logic [1:0]  c;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      c = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_word(d, c);
      expect_frame(d, c, -1, 1'b0, $urandom, 2'($urandom_range(0, 3)), rx);
      checks++;
      if (rx !== model_frame(d, c)) begin
        errors++;
        $display("[TB] FAIL random_%0d got %h exp %h", i, rx, model_frame(d, c));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_input_hold();
    test_back_to_back();
    test_reset_mid_frame();
    test_checksum_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
